// File: rtl/alu_exec_pkg.sv
// Shared constants and records for the ALU execution unit.
// Op 1111 bit-reverse is enabled by the ALU_EXEC_BTR_EN macro.
package alu_exec_pkg;
  localparam int ALU_WIDTH = 16;

  localparam logic [3:0] OP_ROL = 4'b0000;
  localparam logic [3:0] OP_SHL = 4'b0001;
  localparam logic [3:0] OP_ROR = 4'b0010;
  localparam logic [3:0] OP_SHR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_LT  = 4'b1001;
  localparam logic [3:0] OP_LE  = 4'b1010;
  localparam logic [3:0] OP_BTR = 4'b1111;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] data;
    logic                 ofl;
    logic                 cout;
    logic                 zero;
    logic                 neg;
    logic                 err;
  } res_t;

  // Raw request fields held in the stage-1 register.
  typedef struct packed {
    logic [3:0]           oper;
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
    logic                 cin;
    logic                 inva;
    logic                 invb;
    logic                 sign;
  } s1_t;
endpackage

// File: rtl/alu_exec_core.sv
// Combinational ALU: stage-1 request fields in, result record out.
// Op 1111 bit-reverse is enabled by the ALU_EXEC_BTR_EN macro.
module alu_exec_core
  import alu_exec_pkg::*;
(
  input  s1_t  s1,
  output res_t res
);
  logic [ALU_WIDTH-1:0] a, b;
  logic [3:0]           amt;
  logic [ALU_WIDTH:0]   sum;

  always_comb begin
    a   = s1.inva ? ~s1.a : s1.a;
    b   = s1.invb ? ~s1.b : s1.b;
    amt = b[3:0];
    sum = {1'b0, a} + {1'b0, b} + {{ALU_WIDTH{1'b0}}, s1.cin};
    res = '0;
    case (s1.oper)
      // A shift by the full width yields zero, so amt==0 passes A through.
      OP_ROL: res.data = (a << amt) | (a >> (ALU_WIDTH - int'(amt)));
      OP_SHL: res.data = a << amt;
      OP_ROR: res.data = (a >> amt) | (a << (ALU_WIDTH - int'(amt)));
      OP_SHR: res.data = a >> amt;
      OP_ADD: begin
        res.data = sum[ALU_WIDTH-1:0];
        res.cout = sum[ALU_WIDTH];
        res.ofl  = s1.sign ? ((a[ALU_WIDTH-1] == b[ALU_WIDTH-1]) &&
                              (sum[ALU_WIDTH-1] != a[ALU_WIDTH-1]))
                           : sum[ALU_WIDTH];
      end
      OP_AND: res.data = a & b;
      OP_OR:  res.data = a | b;
      OP_XOR: res.data = a ^ b;
      // Compares use the raw operands; invert controls do not apply.
      OP_EQ:  res.data = {{(ALU_WIDTH-1){1'b0}}, s1.a == s1.b};
      OP_LT:  res.data = {{(ALU_WIDTH-1){1'b0}}, $signed(s1.a) <  $signed(s1.b)};
      OP_LE:  res.data = {{(ALU_WIDTH-1){1'b0}}, $signed(s1.a) <= $signed(s1.b)};
`ifdef ALU_EXEC_BTR_EN
      OP_BTR: for (int i = 0; i < ALU_WIDTH; i++) res.data[i] = s1.a[ALU_WIDTH-1-i];
`endif
      default: res.err = 1'b1;
    endcase
    res.zero = (res.data == '0);
    res.neg  = res.data[ALU_WIDTH-1];
  end
endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: operand register, combinational core, 2-entry result FIFO.
// Op 1111 bit-reverse is enabled by the ALU_EXEC_BTR_EN macro.
module alu_exec_unit
  import alu_exec_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_oper,
  input  logic [ALU_WIDTH-1:0] in_a,
  input  logic [ALU_WIDTH-1:0] in_b,
  input  logic                 in_cin,
  input  logic                 in_inva,
  input  logic                 in_invb,
  input  logic                 in_sign,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ALU_WIDTH-1:0] out_data,
  output logic                 out_ofl,
  output logic                 out_cout,
  output logic                 out_zero,
  output logic                 out_neg,
  output logic                 out_err
);
  s1_t        s1_q;
  logic       s1_valid;
  res_t       core_res, head;
  res_t       fifo [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] fifo_count;
  logic       push, pop, accept;

  alu_exec_core u_core (.s1(s1_q), .res(core_res));

  // Stage 1 always drains into the FIFO; in_ready guarantees it has room.
  assign push      = s1_valid;
  assign out_valid = !rst && (fifo_count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = !rst &&
                     (({1'b0, fifo_count} + {2'b0, s1_valid} - {2'b0, pop}) < 3'd2);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_q       <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_q <= '{oper: in_oper, a: in_a, b: in_b, cin: in_cin,
                            inva: in_inva, invb: in_invb, sign: in_sign};
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= core_res;
  end

  assign head     = out_valid ? fifo[rd_ptr] : '0;
  assign out_data = head.data;
  assign out_ofl  = head.ofl;
  assign out_cout = head.cout;
  assign out_zero = head.zero;
  assign out_neg  = head.neg;
  assign out_err  = head.err;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed table-driven bench for alu_exec_unit plus backpressure/reset sequences.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_oper;
  logic [15:0] in_a, in_b;
  logic        in_cin, in_inva, in_invb, in_sign;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic        out_ofl, out_cout, out_zero, out_neg, out_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_oper(in_oper),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_inva(in_inva),
    .in_invb(in_invb), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ofl(out_ofl), .out_cout(out_cout), .out_zero(out_zero),
    .out_neg(out_neg), .out_err(out_err)
  );

  // ctl = {cin, inva, invb, sign}; flg = {ofl, cout, zero, neg, err}
  typedef struct {
    logic [3:0]  oper;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  ctl;
    logic [15:0] d;
    logic [4:0]  flg;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic drv(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [3:0] ctl);
    in_oper = op; in_a = a; in_b = b;
    {in_cin, in_inva, in_invb, in_sign} = ctl;
  endtask

  task automatic offer(input vec_t v, output bit ok);
    @(negedge clk);
    drv(v.oper, v.a, v.b, v.ctl);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      #1 ok = in_ready;
      @(posedge clk);
      if (!ok) @(negedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  initial begin
    bit ok, got;
    int lat, stale;
    logic [15:0] q[$];

    vecs[0]  = '{4'b0100, 16'h7FFF, 16'h0001, 4'b0001, 16'h8000, 5'b10010};
    vecs[1]  = '{4'b0100, 16'h7FFF, 16'h0001, 4'b0000, 16'h8000, 5'b00010};
    vecs[2]  = '{4'b0000, 16'h8001, 16'h0004, 4'b0000, 16'h0018, 5'b00000};
    vecs[3]  = '{4'b0010, 16'h8001, 16'h0004, 4'b0000, 16'h1800, 5'b00000};
    vecs[4]  = '{4'b1001, 16'hFFFF, 16'h0001, 4'b0000, 16'h0001, 5'b00000};
    vecs[5]  = '{4'b1000, 16'h1234, 16'h1234, 4'b0010, 16'h0001, 5'b00000};
    vecs[6]  = '{4'b0001, 16'h8001, 16'h0001, 4'b0000, 16'h0002, 5'b00000};
    vecs[7]  = '{4'b0011, 16'h8001, 16'h0011, 4'b0000, 16'h4000, 5'b00000};
    vecs[8]  = '{4'b0000, 16'hABCD, 16'h0010, 4'b0000, 16'hABCD, 5'b00010};
    vecs[9]  = '{4'b0100, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 5'b11100};
    vecs[10] = '{4'b0100, 16'h0000, 16'h0000, 4'b1101, 16'h0000, 5'b01100};
    vecs[11] = '{4'b0101, 16'hF0F0, 16'hFF00, 4'b0000, 16'hF000, 5'b00010};
    vecs[12] = '{4'b0110, 16'h0F00, 16'h00F0, 4'b0000, 16'h0FF0, 5'b00000};
    vecs[13] = '{4'b0111, 16'hFFFF, 16'hFFFF, 4'b0000, 16'h0000, 5'b00100};
    vecs[14] = '{4'b1010, 16'h8000, 16'h8000, 4'b0000, 16'h0001, 5'b00000};
    vecs[15] = '{4'b1001, 16'h0001, 16'hFFFF, 4'b0000, 16'h0000, 5'b00100};
    vecs[16] = '{4'b1011, 16'h1234, 16'h5678, 4'b0000, 16'h0000, 5'b00101};
`ifdef ALU_EXEC_BTR_EN
    vecs[17] = '{4'b1111, 16'h0001, 16'h0000, 4'b0000, 16'h8000, 5'b00010};
`else
    vecs[17] = '{4'b1111, 16'h0001, 16'h0000, 4'b0000, 16'h0000, 5'b00101};
`endif
    vecs[18] = '{4'b0100, 16'h0005, 16'h0003, 4'b0010, 16'h0001, 5'b11000};
    vecs[19] = '{4'b0010, 16'h0001, 16'h000F, 4'b0000, 16'h0002, 5'b00000};

    // Reset state
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drv(4'b0100, 16'hFFFF, 16'hFFFF, 4'b1111);
    repeat (3) @(negedge clk);
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst flags", {out_ofl, out_cout, out_zero, out_neg, out_err}, 0);
    rst = 1'b0;
    #1 chk("post-rst in_ready", in_ready, 1);

    // Table-driven functional vectors
    for (int i = 0; i < NV; i++) begin
      offer(vecs[i], ok);
      chk($sformatf("v%0d accept", i), ok, 1);
      got = 1'b0; lat = 0;
      for (int n = 0; n < 10 && !got; n++) begin
        @(negedge clk);
        lat++;
        got = out_valid;
      end
      chk($sformatf("v%0d out_valid", i), got, 1);
      chk($sformatf("v%0d latency", i), lat[15:0], 2);
      chk($sformatf("v%0d data", i), out_data, vecs[i].d);
      chk($sformatf("v%0d flags", i),
          {out_ofl, out_cout, out_zero, out_neg, out_err}, vecs[i].flg);
    end

    // Backpressure: two accepted, third stalls until the sink drains
    @(negedge clk);
    out_ready = 1'b0;
    drv(4'b0111, 16'h0001, 16'h0000, 4'b0000); in_valid = 1'b1;
    #1 chk("bp ready0", in_ready, 1);
    @(negedge clk);
    drv(4'b0111, 16'h0002, 16'h0000, 4'b0000);
    #1 chk("bp ready1", in_ready, 1);
    @(negedge clk);
    drv(4'b0111, 16'h0003, 16'h0000, 4'b0000);
    #1 chk("bp ready2", in_ready, 0);
    chk("bp valid2", out_valid, 1);
    chk("bp hold0", out_data, 16'h0001);
    @(negedge clk);
    #1 chk("bp ready3", in_ready, 0);
    chk("bp hold1", out_data, 16'h0001);
    q.delete();
    if (out_valid) q.push_back(out_data);
    out_ready = 1'b1;
    #1 chk("bp ready4", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (out_valid) q.push_back(out_data);
    end
    chk("bp count", q.size(), 3);
    for (int k = 0; k < q.size() && k < 3; k++)
      chk($sformatf("bp order%0d", k), q[k], 16'(k + 1));

    // Reset with two results buffered
    @(negedge clk);
    out_ready = 1'b0;
    drv(4'b0111, 16'h0005, 16'h0000, 4'b0000); in_valid = 1'b1;
    @(negedge clk);
    drv(4'b0111, 16'h0006, 16'h0000, 4'b0000);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 chk("mid valid", out_valid, 1);
    chk("mid data", out_data, 16'h0005);
    chk("mid full", in_ready, 0);
    rst = 1'b1;
    #1 chk("mid rst valid", out_valid, 0);
    chk("mid rst data", out_data, 0);
    chk("mid rst ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("after rst valid", out_valid, 0);
    chk("after rst ready", in_ready, 1);
    out_ready = 1'b1;
    stale = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("stale results", stale[15:0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-002 in_valid  input  1  request present.
REQ-003 in_ready  output  1  request accepted on the clk edge when in_valid is also high.
REQ-004 in_oper  input  4  operation code.
REQ-005 in_a, in_b  input  16 each  raw operands.
REQ-006 in_cin, in_inva, in_invb, in_sign  input  1 each  carry-in, invert A, invert B, signed-overflow select.
REQ-007 out_valid  output  1  result present.
REQ-008 out_ready  input  1  result consumed on the clk edge when out_valid is also high.
REQ-009 out_data  output  16  result.
REQ-010 out_ofl, out_cout, out_zero, out_neg, out_err  output  1 each  result flags.

Function
REQ-011 Datapath: stage-1 operand register, then compute, then 2-entry result FIFO; out_* driven from the FIFO head.
REQ-012 Latency: a request accepted at the end of cycle t SHALL produce out_valid in cycle t+2 if the FIFO was empty.
REQ-013 in_ready = (fifo_count + s1_valid - pop) < 2, where pop = out_valid & out_ready; this is a combinational out_ready->in_ready path; sustained throughput is 1 per cycle.
REQ-014 The A and B operands SHALL be A = in_inva ? ~in_a : in_a, and B likewise with in_invb.
REQ-015 Ops 0000/0001/0010/0011 (rotate left / shift left / rotate right / logical shift right) SHALL act on A, with the amount taken from B[3:0]; a zero amount passes A through.
REQ-016 Op 0100: 17-bit sum {cout,data} = A+B+cin; out_ofl = in_sign ? signed overflow : cout.
REQ-017 Ops 0101/0110/0111: A&B, A|B, A^B.
REQ-018 Ops 1000/1001/1010 SHALL compare raw in_a and in_b as signed values, ignoring the invert inputs, for ==, < and <= respectively; out_data SHALL be 16'h0001 if the comparison holds, else 16'h0000.
REQ-019 Ops 1011-1110 are reserved: out_data=0, out_err=1.
REQ-020 out_zero = (out_data==0) for every op.
REQ-021 out_neg = out_data[15].
REQ-022 out_ofl and out_cout SHALL be 0 except on op 0100.
REQ-023 out_* SHALL hold stable while out_valid & !out_ready.
REQ-024 A push and a pop in the same cycle SHALL be legal at any occupancy, including full.
REQ-025 Results SHALL leave in acceptance order.

Reset
REQ-026 While rst is high: in_ready=0, out_valid=0, all out_* = 0, and s1_valid, FIFO pointers and fifo_count are cleared.
REQ-027 in_ready SHALL go to 1 in the first cycle after rst is deasserted.
REQ-028 A reset asserted mid-operation SHALL discard all in-flight and buffered results; none are delivered afterwards.

Configuration
REQ-029 The block SHALL use macro ALU_EXEC_BTR_EN: when it is defined, op 1111 SHALL give the bit-reverse of raw in_a (out_data[i] = in_a[15-i]) with out_err=0.
REQ-030 When ALU_EXEC_BTR_EN is undefined, op 1111 SHALL be handled as reserved, per REQ-019.

Structure
REQ-031 The shared package alu_exec_pkg SHALL hold the 4-bit op-code constants, ALU_WIDTH=16, and a packed result-record typedef {data, ofl, cout, zero, neg, err}.
REQ-032 The block SHALL contain one combinational sub-module, alu_exec_core: stage-1 fields in, result record out.
REQ-033 The FIFO SHALL be inline in alu_exec_unit.

Verification
REQ-034 Add: oper=0100, in_a=16'h7FFF, in_b=16'h0001, cin=0, sign=1 -> out_data=16'h8000, ofl=1, cout=0, neg=1, zero=0; the same with sign=0 -> ofl=0.
REQ-035 Rotate: oper=0000, in_a=16'h8001, in_b=16'h0004 -> out_data=16'h0018; oper=0010 with the same operands -> out_data=16'h1800.
REQ-036 Compare: oper=1001, in_a=16'hFFFF, in_b=16'h0001 -> out_data=16'h0001; oper=1000, in_a=in_b=16'h1234, invb=1 -> out_data=16'h0001.
REQ-037 Backpressure: out_ready=0 with 3 requests offered back-to-back -> the first 2 are accepted and in_ready=0; set out_ready=1 -> all 3 results delivered in order, with no loss or duplication.
REQ-038 Reset mid-flight: 2 results buffered, then rst pulsed for 1 cycle -> out_valid=0 for the whole cycle after rst and no stale result appears later.
REQ-039 Config: oper=1111, in_a=16'h0001 -> out_data=16'h8000, err=0 with ALU_EXEC_BTR_EN defined; out_data=0, err=1 without it.
